// File: rtl/hypot_iter_unit.sv
// Iterative integer magnitude sqrt(x^2 + y^2) with valid/ready handshake.
// One result bit per cycle from a restoring digit-by-digit square root.
module hypot_iter_unit #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         round_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   result,
    output logic         exact,
    output logic         busy
);
    localparam int SW = 2*W + 2;
    localparam int CW = $clog2(W + 2);

    // state   | meaning
    // IDLE    | waiting for operands, in_ready high
    // SQUARE  | form radicand x*x + y*y, clear root state
    // ROOT    | W+1 root iterations, one result bit each
    // DONE    | result presented until out_ready
    typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;

    state_t        r_state, w_next;
    logic [W-1:0]  r_x, r_y;
    logic          r_mode;
    logic [SW-1:0] r_rad;
    logic [W:0]    r_q;
    logic [W+1:0]  r_rem;
    logic [CW-1:0] r_cnt;
    logic [W:0]    r_result;
    logic          r_exact;

    logic [SW-1:0] w_x_ext, w_y_ext, w_sq;
    logic [W+3:0]  w_trial, w_cmp;
    logic          w_take, w_last;
    logic [W+1:0]  w_rem_next;
    logic [W:0]    w_q_next;

    assign w_x_ext = {{(SW-W){1'b0}}, r_x};
    assign w_y_ext = {{(SW-W){1'b0}}, r_y};
    assign w_sq    = w_x_ext * w_x_ext + w_y_ext * w_y_ext;

    // Remainder stays below 2q+1, so W+2 bits hold it; the low-bit subtract is exact.
    assign w_trial    = {r_rem, r_rad[SW-1 -: 2]};
    assign w_cmp      = {1'b0, r_q, 2'b01};
    assign w_take     = (w_trial >= w_cmp);
    assign w_rem_next = w_take ? (w_trial[W+1:0] - w_cmp[W+1:0]) : w_trial[W+1:0];
    assign w_q_next   = {r_q[W-1:0], w_take};
    assign w_last     = (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = SQUARE;
            SQUARE:  w_next = ROOT;
            ROOT:    if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_mode   <= 1'b0;
            r_rad    <= '0;
            r_q      <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_exact  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x    <= x;
                        r_y    <= y;
                        r_mode <= round_mode;
                    end
                end
                SQUARE: begin
                    r_rad <= w_sq;
                    r_q   <= '0;
                    r_rem <= '0;
                    r_cnt <= CW'(W + 1);
                end
                ROOT: begin
                    r_rad <= r_rad << 2;
                    r_q   <= w_q_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_exact <= (w_rem_next == '0);
                        // Round up when S exceeds q^2 + q; q+1 always fits W+1 bits.
                        if (r_mode && (w_rem_next > {1'b0, w_q_next}))
                            r_result <= w_q_next + {{W{1'b0}}, 1'b1};
                        else
                            r_result <= w_q_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign exact     = r_exact;
endmodule
